// File: rtl/traffic_ctrl_param.sv
// traffic_ctrl_param: parametrised two-axis intersection controller.
// One FSM sequences NS_GO -> NS_Y1 -> NS_LEFT -> NS_Y2 -> EW_GO -> EW_Y1 ->
// EW_LEFT -> EW_Y2 and wraps, advancing only on i_tick. Pedestrian heads are
// served on latched request (or always when PED_AUTO=1); a night flash mode
// can be entered at the cycle wrap point.
// Optional feature macro: TRAFFIC_EMERG_EN adds i_emerg and an ALL_RED state.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   i_start               leave IDLE (level)
//   i_tick                timing enable
//   i_night               night flash request (level, sampled at wrap)
//   i_ped_req_ns/_ew      pedestrian request pulses
//   i_emerg               emergency hold (only with TRAFFIC_EMERG_EN)
//   o_ns_car/o_ew_car     car heads: 00 RED, 01 GREEN, 10 YELLOW, 11 LEFT
//   o_ns_ped/o_ew_ped     ped heads: 00 RED, 01 GREEN, 10 BLINK
//   o_cycle               tick position in cycle 1..TOTAL, 0 when not running
//   o_ped_pend            latched requests {ew,ns}
module traffic_ctrl_param #(
    parameter int unsigned T_GREEN    = 20,
    parameter int unsigned T_BLINK    = 6,
    parameter int unsigned T_YELLOW   = 2,
    parameter int unsigned T_LEFT     = 10,
    parameter int unsigned FLASH_HALF = 1,
    parameter int unsigned PED_AUTO   = 0,
    parameter int unsigned CYC_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_tick,
    input  logic             i_night,
    input  logic             i_ped_req_ns,
    input  logic             i_ped_req_ew,
`ifdef TRAFFIC_EMERG_EN
    input  logic             i_emerg,
`endif
    output logic [1:0]       o_ns_car,
    output logic [1:0]       o_ns_ped,
    output logic [1:0]       o_ew_car,
    output logic [1:0]       o_ew_ped,
    output logic [CYC_W-1:0] o_cycle,
    output logic [1:0]       o_ped_pend
);

    localparam int unsigned MAX_A   = (T_GREEN > T_LEFT) ? T_GREEN : T_LEFT;
    localparam int unsigned MAX_B   = (T_YELLOW > FLASH_HALF) ? T_YELLOW : FLASH_HALF;
    localparam int unsigned MAX_LEN = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CNT_W   = $clog2(MAX_LEN + 1);

    localparam logic [1:0] CAR_RED    = 2'b00;
    localparam logic [1:0] CAR_GREEN  = 2'b01;
    localparam logic [1:0] CAR_YELLOW = 2'b10;
    localparam logic [1:0] CAR_LEFT   = 2'b11;
    localparam logic [1:0] PED_RED    = 2'b00;
    localparam logic [1:0] PED_GREEN  = 2'b01;
    localparam logic [1:0] PED_BLINK  = 2'b10;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        NS_GO   = 4'd1,
        NS_Y1   = 4'd2,
        NS_LEFT = 4'd3,
        NS_Y2   = 4'd4,
        EW_GO   = 4'd5,
        EW_Y1   = 4'd6,
        EW_LEFT = 4'd7,
        EW_Y2   = 4'd8,
        NIGHT   = 4'd9
`ifdef TRAFFIC_EMERG_EN
        ,
        ALL_RED = 4'd10
`endif
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CYC_W-1:0]   cycle_q, cycle_d;
    logic               flash_q, flash_d;
    logic [1:0]         pend_q, pend_d;
    // srv[0]: NS ped head served in current EW_GO; srv[1]: EW ped head in NS_GO
    logic [1:0]         srv_q, srv_d;
    logic [1:0]         ns_car_q, ns_car_d, ew_car_q, ew_car_d;
    logic [1:0]         ns_ped_q, ns_ped_d, ew_ped_q, ew_ped_d;
    logic [CNT_W-1:0]   len_c;
    logic [1:0]         ped_lvl_c;

    // Length of the current phase (flash half-period in NIGHT)
    always_comb begin
        len_c = CNT_W'(T_GREEN);
        case (state_q)
            NS_GO, EW_GO:               len_c = CNT_W'(T_GREEN);
            NS_Y1, NS_Y2, EW_Y1, EW_Y2: len_c = CNT_W'(T_YELLOW);
            NS_LEFT, EW_LEFT:           len_c = CNT_W'(T_LEFT);
            NIGHT:                      len_c = CNT_W'(FLASH_HALF);
            default:                    len_c = CNT_W'(T_GREEN);
        endcase
    end

    // Next state, counters, request latches and registered output decode
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cycle_d   = cycle_q;
        flash_d   = flash_q;
        pend_d    = pend_q;
        srv_d     = srv_q;
        ns_car_d  = CAR_RED;
        ew_car_d  = CAR_RED;
        ns_ped_d  = PED_RED;
        ew_ped_d  = PED_RED;
        ped_lvl_c = PED_RED;

        if (state_q != IDLE) begin
            pend_d = pend_q | {i_ped_req_ew, i_ped_req_ns};
        end

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = NS_GO;
                    cnt_d   = CNT_W'(1);
                    cycle_d = CYC_W'(1);
                end
            end
            NIGHT: begin
                // Leaving night does not wait for a tick
                if (!i_night) begin
                    state_d = NS_GO;
                    cnt_d   = CNT_W'(1);
                    cycle_d = CYC_W'(1);
                    flash_d = 1'b0;
                end else if (i_tick) begin
                    if (cnt_q == len_c) begin
                        flash_d = ~flash_q;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
`ifdef TRAFFIC_EMERG_EN
            ALL_RED: begin
                if (i_tick && !i_emerg) begin
                    state_d = NS_GO;
                    cnt_d   = CNT_W'(1);
                    cycle_d = CYC_W'(1);
                end
            end
`endif
            default: begin
                if (i_tick) begin
                    cycle_d = cycle_q + CYC_W'(1);
                    if (cnt_q == len_c) begin
                        cnt_d = CNT_W'(1);
                        case (state_q)
                            NS_GO:   state_d = NS_Y1;
                            NS_Y1:   state_d = NS_LEFT;
                            NS_LEFT: state_d = NS_Y2;
                            NS_Y2:   state_d = EW_GO;
                            EW_GO:   state_d = EW_Y1;
                            EW_Y1:   state_d = EW_LEFT;
                            EW_LEFT: state_d = EW_Y2;
                            EW_Y2: begin
                                if (i_night) begin
                                    state_d = NIGHT;
                                    cycle_d = '0;
                                    flash_d = 1'b0;
                                end else begin
                                    state_d = NS_GO;
                                    cycle_d = CYC_W'(1);
                                end
                            end
                            default: state_d = state_q;
                        endcase
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
`ifdef TRAFFIC_EMERG_EN
                    // Emergency cuts GO/LEFT short; yellows run out, then hold ALL_RED
                    if (i_emerg) begin
                        case (state_q)
                            NS_GO: begin
                                state_d = NS_Y1;
                                cnt_d   = CNT_W'(1);
                            end
                            NS_LEFT: begin
                                state_d = NS_Y2;
                                cnt_d   = CNT_W'(1);
                            end
                            EW_GO: begin
                                state_d = EW_Y1;
                                cnt_d   = CNT_W'(1);
                            end
                            EW_LEFT: begin
                                state_d = EW_Y2;
                                cnt_d   = CNT_W'(1);
                            end
                            NS_Y1, NS_Y2, EW_Y1, EW_Y2: begin
                                if (cnt_q == len_c) begin
                                    state_d = ALL_RED;
                                    cycle_d = '0;
                                end
                            end
                            default: ;
                        endcase
                    end
`endif
                end
            end
        endcase

        // GO entry decides ped service; clearing beats a same-edge request
        if (state_d == NS_GO && state_q != NS_GO) begin
            srv_d[1]  = (PED_AUTO != 0) || pend_d[1];
            pend_d[1] = 1'b0;
        end
        if (state_d == EW_GO && state_q != EW_GO) begin
            srv_d[0]  = (PED_AUTO != 0) || pend_d[0];
            pend_d[0] = 1'b0;
        end

        ped_lvl_c = (cnt_d <= CNT_W'(T_GREEN - T_BLINK)) ? PED_GREEN : PED_BLINK;

        case (state_d)
            NS_GO: begin
                ns_car_d = CAR_GREEN;
                if (srv_d[1]) ew_ped_d = ped_lvl_c;
            end
            NS_Y1, NS_Y2: ns_car_d = CAR_YELLOW;
            NS_LEFT:      ns_car_d = CAR_LEFT;
            EW_GO: begin
                ew_car_d = CAR_GREEN;
                if (srv_d[0]) ns_ped_d = ped_lvl_c;
            end
            EW_Y1, EW_Y2: ew_car_d = CAR_YELLOW;
            EW_LEFT:      ew_car_d = CAR_LEFT;
            NIGHT: begin
                ns_car_d = flash_d ? CAR_RED : CAR_YELLOW;
                ew_car_d = flash_d ? CAR_RED : CAR_YELLOW;
            end
            default: ;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            cycle_q  <= '0;
            flash_q  <= 1'b0;
            pend_q   <= '0;
            srv_q    <= '0;
            ns_car_q <= CAR_RED;
            ew_car_q <= CAR_RED;
            ns_ped_q <= PED_RED;
            ew_ped_q <= PED_RED;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cycle_q  <= cycle_d;
            flash_q  <= flash_d;
            pend_q   <= pend_d;
            srv_q    <= srv_d;
            ns_car_q <= ns_car_d;
            ew_car_q <= ew_car_d;
            ns_ped_q <= ns_ped_d;
            ew_ped_q <= ew_ped_d;
        end
    end

    assign o_ns_car   = ns_car_q;
    assign o_ew_car   = ew_car_q;
    assign o_ns_ped   = ns_ped_q;
    assign o_ew_ped   = ew_ped_q;
    assign o_cycle    = cycle_q;
    assign o_ped_pend = pend_q;

endmodule

// File: tb/tb_traffic_ctrl_param.sv
// Bench for traffic_ctrl_param: two instances (PED_AUTO=0 and 1) share stimulus.
module tb_traffic_ctrl_param;

    localparam int TG    = 20;
    localparam int TBL   = 6;
    localparam int TY    = 2;
    localparam int TL    = 10;
    localparam int FH    = 1;
    localparam int HALF  = TG + 2*TY + TL;
    localparam int TOTAL = 2*HALF;

    logic clk = 1'b0;
    logic rst_n, start, tick, night, req_ns, req_ew;
`ifdef TRAFFIC_EMERG_EN
    logic emerg = 1'b0;
`endif
    logic [1:0] ns_car0, ns_ped0, ew_car0, ew_ped0, pend0;
    logic [1:0] ns_cara, ns_peda, ew_cara, ew_peda, penda;
    logic [7:0] cyc0, cyca;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    traffic_ctrl_param #(.PED_AUTO(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .i_start(start), .i_tick(tick), .i_night(night),
        .i_ped_req_ns(req_ns), .i_ped_req_ew(req_ew),
`ifdef TRAFFIC_EMERG_EN
        .i_emerg(emerg),
`endif
        .o_ns_car(ns_car0), .o_ns_ped(ns_ped0), .o_ew_car(ew_car0), .o_ew_ped(ew_ped0),
        .o_cycle(cyc0), .o_ped_pend(pend0));

    traffic_ctrl_param #(.PED_AUTO(1)) duta (
        .clk(clk), .rst_n(rst_n), .i_start(start), .i_tick(tick), .i_night(night),
        .i_ped_req_ns(req_ns), .i_ped_req_ew(req_ew),
`ifdef TRAFFIC_EMERG_EN
        .i_emerg(emerg),
`endif
        .o_ns_car(ns_cara), .o_ns_ped(ns_peda), .o_ew_car(ew_cara), .o_ew_ped(ew_peda),
        .o_cycle(cyca), .o_ped_pend(penda));

    // Reference model: mode 0 idle, 1 running at position m_pos, 2 night flash
    int         m_mode, m_pos, m_fticks;
    bit         m_flash, m_srv_ns, m_srv_ew;
    logic [1:0] m_pend;

    function automatic void m_reset();
        m_mode = 0; m_pos = 0; m_fticks = 0; m_flash = 0;
        m_srv_ns = 0; m_srv_ew = 0; m_pend = 2'b00;
    endfunction

    function automatic void m_set_pos(int p);
        m_pos = p;
        if (p == 1) begin
            m_srv_ew = m_pend[1]; m_pend[1] = 1'b0;
        end
        if (p == HALF + 1) begin
            m_srv_ns = m_pend[0]; m_pend[0] = 1'b0;
        end
    endfunction

    function automatic void m_edge();
        if (!rst_n) begin
            m_reset();
            return;
        end
        if (m_mode != 0) m_pend = m_pend | {req_ew, req_ns};
        if (m_mode == 0) begin
            if (start) begin m_mode = 1; m_set_pos(1); end
        end else if (m_mode == 2) begin
            if (!night) begin
                m_mode = 1; m_flash = 0; m_set_pos(1);
            end else if (tick) begin
                m_fticks++;
                if (m_fticks == FH) begin m_flash = !m_flash; m_fticks = 0; end
            end
        end else if (tick) begin
            if (m_pos == TOTAL) begin
                if (night) begin
                    m_mode = 2; m_pos = 0; m_flash = 0; m_fticks = 0;
                end else m_set_pos(1);
            end else m_set_pos(m_pos + 1);
        end
    endfunction

    // ax 0 = NS, 1 = EW
    function automatic int m_car(int ax);
        int q;
        if (m_mode == 2) return m_flash ? 0 : 2;
        if (m_mode != 1) return 0;
        q = m_pos - (ax == 1 ? HALF : 0);
        if (q < 1 || q > HALF) return 0;
        if (q <= TG) return 1;
        if (q <= TG + TY) return 2;
        if (q <= TG + TY + TL) return 3;
        return 2;
    endfunction

    // Ped head crossing axis ax runs during the other axis's GO phase
    function automatic int m_ped(int ax, bit srv);
        int q;
        if (m_mode != 1 || !srv) return 0;
        q = m_pos - (ax == 0 ? HALF : 0);
        if (q < 1 || q > TG) return 0;
        return (q <= TG - TBL) ? 1 : 2;
    endfunction

    function automatic void chk(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endfunction

    function automatic void check_all();
        int ec;
        ec = (m_mode == 1) ? m_pos : 0;
        chk("d0_cycle",  int'(cyc0),    ec);
        chk("d0_ns_car", int'(ns_car0), m_car(0));
        chk("d0_ew_car", int'(ew_car0), m_car(1));
        chk("d0_ns_ped", int'(ns_ped0), m_ped(0, m_srv_ns));
        chk("d0_ew_ped", int'(ew_ped0), m_ped(1, m_srv_ew));
        chk("d0_pend",   int'(pend0),   int'(m_pend));
        chk("da_cycle",  int'(cyca),    ec);
        chk("da_ns_ped", int'(ns_peda), m_ped(0, 1'b1));
        chk("da_ew_ped", int'(ew_peda), m_ped(1, 1'b1));
        chk("da_pend",   int'(penda),   int'(m_pend));
    endfunction

    task automatic step();
        @(posedge clk);
        m_edge();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; tick = 1'b1; night = 1'b0;
        req_ns = 1'b0; req_ew = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic go();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    typedef struct {
        int         pos;
        int         e_cyc;
        logic [1:0] e_ns_car;
        logic [1:0] e_ew_car;
        logic [1:0] e_ns_ped;
        logic [1:0] e_ew_ped;
    } vec_t;

    vec_t tbl[20];

    initial begin
        int cur;
        tbl = '{
            '{1,  1,  2'b01, 2'b00, 2'b00, 2'b01},
            '{14, 14, 2'b01, 2'b00, 2'b00, 2'b01},
            '{15, 15, 2'b01, 2'b00, 2'b00, 2'b10},
            '{20, 20, 2'b01, 2'b00, 2'b00, 2'b10},
            '{21, 21, 2'b10, 2'b00, 2'b00, 2'b00},
            '{22, 22, 2'b10, 2'b00, 2'b00, 2'b00},
            '{23, 23, 2'b11, 2'b00, 2'b00, 2'b00},
            '{32, 32, 2'b11, 2'b00, 2'b00, 2'b00},
            '{33, 33, 2'b10, 2'b00, 2'b00, 2'b00},
            '{34, 34, 2'b10, 2'b00, 2'b00, 2'b00},
            '{35, 35, 2'b00, 2'b01, 2'b01, 2'b00},
            '{48, 48, 2'b00, 2'b01, 2'b01, 2'b00},
            '{49, 49, 2'b00, 2'b01, 2'b10, 2'b00},
            '{54, 54, 2'b00, 2'b01, 2'b10, 2'b00},
            '{55, 55, 2'b00, 2'b10, 2'b00, 2'b00},
            '{57, 57, 2'b00, 2'b11, 2'b00, 2'b00},
            '{66, 66, 2'b00, 2'b11, 2'b00, 2'b00},
            '{67, 67, 2'b00, 2'b10, 2'b00, 2'b00},
            '{68, 68, 2'b00, 2'b10, 2'b00, 2'b00},
            '{69, 1,  2'b01, 2'b00, 2'b00, 2'b01}
        };
        m_reset();

        // Reset state
        do_reset();
        chk("rst_cycle",  int'(cyc0),    0);
        chk("rst_ns_car", int'(ns_car0), 0);
        chk("rst_ew_car", int'(ew_car0), 0);
        chk("rst_pend",   int'(pend0),   0);

        // Full cycle with PED_AUTO=1 instance against hand-derived table
        go();
        cur = 1;
        for (int i = 0; i < 20; i++) begin
            while (cur < tbl[i].pos) begin step(); cur++; end
            chk("tbl_cycle",  int'(cyca),    tbl[i].e_cyc);
            chk("tbl_ns_car", int'(ns_cara), int'(tbl[i].e_ns_car));
            chk("tbl_ew_car", int'(ew_cara), int'(tbl[i].e_ew_car));
            chk("tbl_ns_ped", int'(ns_peda), int'(tbl[i].e_ns_ped));
            chk("tbl_ew_ped", int'(ew_peda), int'(tbl[i].e_ew_ped));
        end

        // PED_AUTO=0: NS request at cycle 10 served in the following EW_GO
        do_reset();
        go();
        repeat (4) step();
        chk("noreq_ew_ped", int'(ew_ped0), 0);
        repeat (5) step();                   // cycle 10
        req_ns = 1'b1;
        step();                              // cycle 11
        req_ns = 1'b0;
        chk("req_pend_set", int'(pend0), 1);
        repeat (23) step();                  // cycle 34
        chk("req_pend_hold", int'(pend0), 1);
        chk("req_ew_ped_red", int'(ew_ped0), 0);
        step();                              // cycle 35
        chk("req_pend_clr", int'(pend0), 0);
        chk("req_ns_ped_35", int'(ns_ped0), 1);
        repeat (13) step();                  // cycle 48
        chk("req_ns_ped_48", int'(ns_ped0), 1);
        step();                              // cycle 49
        chk("req_ns_ped_49", int'(ns_ped0), 2);
        repeat (5) step();                   // cycle 54
        chk("req_ns_ped_54", int'(ns_ped0), 2);
        step();                              // cycle 55
        chk("req_ns_ped_55", int'(ns_ped0), 0);
        repeat (48) step();                  // cycle 35 of next round, no request
        chk("req_ns_ped_unserved", int'(ns_ped0), 0);

        // Tick every third clock
        do_reset();
        go();
        for (int k = 0; k < 42; k++) begin
            tick = (k % 3 == 2);
            step();
        end
        chk("tick3_cycle", int'(cyca), 15);
        chk("tick3_ew_ped", int'(ew_peda), 2);
        for (int k = 42; k < 3 * 70; k++) begin
            tick = (k % 3 == 2);
            step();
        end
        tick = 1'b1;

        // Night mode requested mid-cycle, taken at the wrap
        do_reset();
        go();
        repeat (39) step();                  // cycle 40
        night = 1'b1;
        repeat (28) step();                  // cycle 68
        chk("night_pre", int'(cyc0), 68);
        step();
        chk("night_cycle", int'(cyc0), 0);
        chk("night_ns_y", int'(ns_car0), 2);
        chk("night_ew_y", int'(ew_car0), 2);
        step();
        chk("night_ns_r", int'(ns_car0), 0);
        chk("night_ew_r", int'(ew_car0), 0);
        step();
        chk("night_ns_y2", int'(ns_car0), 2);
        night = 1'b0;
        step();
        chk("night_exit_cycle", int'(cyc0), 1);
        chk("night_exit_ns", int'(ns_car0), 1);

        // Asynchronous reset in the middle of NS_LEFT
        do_reset();
        go();
        repeat (20) step();                  // cycle 21
        req_ew = 1'b1;
        step();                              // cycle 22
        req_ew = 1'b0;
        repeat (3) step();                   // cycle 25
        chk("mid_ns_left", int'(ns_car0), 3);
        chk("mid_pend", int'(pend0), 2);
        #2;
        rst_n = 1'b0;
        m_reset();
        #1;
        chk("arst_cycle", int'(cyc0), 0);
        chk("arst_ns_car", int'(ns_car0), 0);
        chk("arst_pend", int'(pend0), 0);
        check_all();
        step();
        rst_n = 1'b1;
        repeat (3) step();
        chk("arst_idle", int'(cyc0), 0);
        go();
        chk("arst_restart", int'(cyc0), 1);

        // Randomised run against the model
        for (int k = 0; k < 4000; k++) begin
            tick   = ($urandom_range(0, 3) != 0);
            req_ns = ($urandom_range(0, 15) == 0);
            req_ew = ($urandom_range(0, 15) == 0);
            start  = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 149) == 0) night = !night;
            if ($urandom_range(0, 1499) == 0) begin
                rst_n = 1'b0;
                m_reset();
                #1;
                check_all();
                step();
                rst_n = 1'b1;
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/traffic_ctrl_param.md
Name: traffic_ctrl_param

Overview:
Parametrised two-axis intersection controller; successor to the fixed 68-cycle, four-instance light sequencer.
- One FSM drives the north-south (NS) and east-west (EW) car and pedestrian heads.
- Phase lengths are parameters. Timing advances on an enable tick.
- Pedestrian phases are served on request. A night flash mode is available.
- Sits under the intersection top; feeds the display/monitor logic through o_cycle.

Parameters:
T_GREEN, 20, ticks in each GO phase, blink window included (>= T_BLINK+1)
T_BLINK, 6, ticks at end of GO phase during which served ped head blinks (>=1)
T_YELLOW, 2, ticks per yellow phase (>=1)
T_LEFT, 10, ticks per left-turn phase (>=1)
FLASH_HALF, 1, ticks per half-period of night flash (>=1)
PED_AUTO, 0, 1 = ped phase served every cycle regardless of requests
CYC_W, 8, width of o_cycle; must hold TOTAL = 2*(T_GREEN+2*T_YELLOW+T_LEFT)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
i_start  input  1  leave IDLE (level, sampled per clock)
i_tick  input  1  timing enable; tie 1 for one tick per clock
i_night  input  1  request night flash mode (level)
i_ped_req_ns  input  1  pedestrian request to cross NS approaches (pulse)
i_ped_req_ew  input  1  pedestrian request to cross EW approaches (pulse)
o_ns_car  output  2  NS car head: 00 RED, 01 GREEN, 10 YELLOW, 11 LEFT
o_ns_ped  output  2  NS ped head: 00 RED, 01 GREEN, 10 BLINK
o_ew_car  output  2  EW car head, same encoding
o_ew_ped  output  2  EW ped head, same encoding
o_cycle  output  CYC_W  tick position in cycle, 1..TOTAL; 0 when IDLE/NIGHT
o_ped_pend  output  2  latched requests {ew,ns}

Behaviour:
- Clock is clk. Reset rst_n is asynchronous, active-low.
- Reset (any time, including mid-phase): state IDLE, o_cycle 0, all heads RED, request latches 0, flash phase 0. Outputs take these values immediately.
- States: IDLE, NS_GO, NS_Y1, NS_LEFT, NS_Y2, EW_GO, EW_Y1, EW_LEFT, EW_Y2, NIGHT.
- Output decoding is registered; outputs change on the same edge as the state.
- IDLE -> NS_GO on any edge with i_start=1; i_tick not required. That edge sets o_cycle=1 and phase counter=1.
- Run states, each edge with i_tick=1:
  - If phase counter == phase length: advance state, counter=1.
  - Otherwise: counter+1.
  - o_cycle increments every tick.
  - The EW_Y2 -> NS_GO wrap sets o_cycle=1.
- Edges with i_tick=0: no change, except request latching.
- Phase lengths: GO = T_GREEN; Y1 and Y2 = T_YELLOW; LEFT = T_LEFT.
- Car heads:
  - X_GO: X car GREEN. X_Y1/X_Y2: X car YELLOW. X_LEFT: X car LEFT.
  - The other axis car is RED throughout.
- Ped heads:
  - During EW_GO the NS ped head is active; during NS_GO the EW ped head is active. All other states: ped RED.
  - Active head shows GREEN while counter <= T_GREEN-T_BLINK, then BLINK.
  - A GO phase is served if PED_AUTO=1, or if the relevant latch (or same-edge request input) is set at GO entry; otherwise the ped head stays RED for that GO.
- Request latches:
  - Set on request pulse in any state except IDLE.
  - Cleared on the edge entering the serving GO phase.
  - Set wins over clear only for a request arriving after the entry edge.
- Night mode:
  - At the EW_Y2 end (wrap point), if i_night=1, go to NIGHT instead of NS_GO; o_cycle=0.
  - In NIGHT: both car heads flash YELLOW/RED, starting YELLOW, toggling every FLASH_HALF ticks. Peds RED.
  - Edge with i_night=0 in NIGHT -> NS_GO, o_cycle=1, flash phase reset.
- i_start is ignored outside IDLE. i_night is ignored mid-cycle.

Optional Feature:
TRAFFIC_EMERG_EN
- Defined:
  - Adds input i_emerg (1 bit) and state ALL_RED.
  - i_emerg=1 in any GO or LEFT state: next tick moves to that axis's following yellow, counter=1.
  - i_emerg=1 in yellow states: yellow completes normally.
  - Then ALL_RED: all heads RED, o_cycle 0, held while i_emerg=1.
  - Release: next tick -> NS_GO, o_cycle=1. Latches preserved.
  - i_emerg has priority over i_night.
- Undefined: no port, no ALL_RED state; behaviour as above.

Test Plan:
- Defaults, PED_AUTO=1, i_tick=1, i_start=1 after reset:
  - o_cycle runs 1..68 then wraps to 1.
  - Cycles 1-14: ns_car=01, ew_ped=01.
  - Cycles 15-20: ew_ped=10.
  - Cycles 21-22 and 33-34: ns_car=10.
  - Cycles 23-32: ns_car=11.
  - Cycles 35-68: mirrored for EW.
- PED_AUTO=0, no requests: ped heads stay 00 for a full cycle.
- PED_AUTO=0, pulse i_ped_req_ns at cycle 10: o_ped_pend=01 until cycle 35 entry. ns_ped=01 for cycles 35-48 and 10 for cycles 49-54; latch then 0.
- i_tick=1 every third clock: each state holds 3 clocks per tick; sequence identical to the first scenario, stretched ×3.
- i_night=1 during cycle 40: after cycle 68, o_cycle=0, cars alternate 10/00 each tick. Drop i_night: next edge o_cycle=1, ns_car=01.
- rst_n low mid-NS_LEFT (cycle 25): outputs immediately 00, o_cycle 0, latches 0. Stays in IDLE after release until i_start.
